fetch_sequencer: RTL and testbench
==================================

FETCH_SEQUENCER -- requirements
Module: fetch_sequencer

Interface
REQ-001 SHALL provide the parameter WAIT_LIMIT, default 15, which is the maximum number of FETCH cycles with mem_ready low before a bus error.
REQ-002 SHALL have exactly one clock and reset is synchronous and active-high.
REQ-003 clk  in  1  sole clock; all state updates on rising edge.
REQ-004 reset  in  1  synchronous, active-high.
REQ-005 run  in  1  start/resume request; sampled only in HALT.
REQ-006 halt_req  in  1  stop request from decode (stp).
REQ-007 mem_ready  in  1  instruction RAM read data valid.
REQ-008 ram_q  in  16  instruction RAM read data.
REQ-009 ir_en  in  1  IR load enable from decoder.
REQ-010 pc_cnt_en  in  1  PC increment enable from decoder.
REQ-011 pc_sload  in  1  PC synchronous load enable from decoder.
REQ-012 pc_load_value  in  16  jump target for pc_sload.
REQ-013 sm_extra  in  1  decoder request for a second execute cycle.
REQ-014 state  out  2  phase code: FETCH=2'b00, EXEC1=2'b10, EXEC2=2'b01, HALT=2'b11.
REQ-015 instruction  out  16  instruction register, fed to decoder.
REQ-016 pc  out  16  program counter; drives the instruction RAM address.
REQ-017 halted  out  1  high while in HALT.
REQ-018 bus_err  out  1  sticky fetch-timeout flag.

Function
REQ-019 SHALL implement a 4-state FSM (HALT, FETCH, EXEC1, EXEC2), registered, with state output decoded directly from it.
REQ-020 HALT: run=1 -> FETCH next cycle, and bus_err cleared; else remain.
REQ-021 FETCH: mem_ready=1 -> EXEC1; mem_ready=0 -> remain and increment wait counter.
REQ-022 FETCH: wait counter reaching WAIT_LIMIT with mem_ready still 0 -> HALT, bus_err set to 1.
REQ-023 Wait counter SHALL clear on every entry to FETCH and never wrap.
REQ-024 EXEC1: halt_req=1 -> HALT; else sm_extra=1 -> EXEC2; else FETCH.
REQ-025 EXEC2: halt_req=1 -> HALT; else FETCH; sm_extra ignored (no EXEC3).
REQ-026 IR SHALL load ram_q when ir_en=1 and mem_ready=1 and FSM is not HALT; otherwise it holds.
REQ-027 PC update SHALL occur only outside HALT; in FETCH it is additionally qualified by mem_ready=1.
REQ-028 PC priority: pc_sload (pc <= pc_load_value) over pc_cnt_en (pc <= pc+1).
REQ-029 PC increment SHALL wrap 16'hFFFF -> 16'h0000 silently.
REQ-030 halted SHALL be 1 exactly when FSM is HALT (registered, same cycle as state=2'b11).
REQ-031 run asserted outside HALT SHALL have no effect; halt_req asserted in FETCH or HALT SHALL have no effect.
REQ-032 halt_req and sm_extra both high in EXEC1 SHALL resolve as halt; that instruction's EXEC2 is skipped.
REQ-033 PC and IR updates in the cycle that transitions to HALT SHALL still take effect.

Reset
REQ-034 reset=1 at a clock edge SHALL force FSM=HALT, state=2'b11, pc=16'h0000, instruction=16'h0000, halted=1, bus_err=0, and wait counter=0, from any state including mid-fetch wait.
REQ-035 reset SHALL dominate run, halt_req, and all enables in the same cycle.

Verification
REQ-036 Reset, then pulse run, with mem_ready tied high, and ram_q=16'h4C00 with ir_en=1 in FETCH and pc_cnt_en=1 in FETCH, sm_extra=0 -> state sequence 11,00,10,00,10; pc increments to 1, then 2; instruction=16'h4C00.
REQ-037 In EXEC1 assert sm_extra=1 -> next state 01 (EXEC2), then 00; exactly one EXEC2 cycle.
REQ-038 In FETCH hold mem_ready=0 for 3 cycles, then 1 -> state stays 00 for 4 cycles; pc and IR change only on the mem_ready=1 cycle; bus_err=0.
REQ-039 In FETCH hold mem_ready=0 for WAIT_LIMIT cycles -> HALT, bus_err=1, halted=1; a later run pulse -> FETCH with bus_err=0.
REQ-040 In EXEC1 assert pc_sload=1, pc_cnt_en=1, pc_load_value=16'h0123, halt_req=1 -> pc=16'h0123, state=11; with pc=16'hFFFF, an increment -> 16'h0000.
REQ-041 Assert reset during a FETCH wait and during EXEC2 -> next cycle: all outputs at their REQ-034 values.

Source files
------------

// File: rtl/fetch_sequencer_if.sv
// fetch_sequencer_if: run/stop, instruction RAM and decoder signals for the fetch sequencer.
interface fetch_sequencer_if;
  logic        run;
  logic        halt_req;
  logic        mem_ready;
  logic [15:0] ram_q;
  logic        ir_en;
  logic        pc_cnt_en;
  logic        pc_sload;
  logic [15:0] pc_load_value;
  logic        sm_extra;
  logic [1:0]  state;
  logic [15:0] instruction;
  logic [15:0] pc;
  logic        halted;
  logic        bus_err;
  modport slave (
    input  run, halt_req, mem_ready, ram_q, ir_en, pc_cnt_en, pc_sload, pc_load_value, sm_extra,
    output state, instruction, pc, halted, bus_err
  );
  modport master (
    output run, halt_req, mem_ready, ram_q, ir_en, pc_cnt_en, pc_sload, pc_load_value, sm_extra,
    input  state, instruction, pc, halted, bus_err
  );
endinterface

// File: rtl/fetch_sequencer.sv
// fetch_sequencer: HALT/FETCH/EXEC1/EXEC2 phase FSM owning the PC, IR and fetch-timeout flag.
module fetch_sequencer #(
  parameter int WAIT_LIMIT = 15
) (
  input  logic             clk,
  input  logic             reset,
  fetch_sequencer_if.slave bus
);
  typedef enum logic [1:0] {FETCH = 2'b00, EXEC2 = 2'b01, EXEC1 = 2'b10, HALT = 2'b11} state_t;
  localparam int CW = $clog2(WAIT_LIMIT + 1);
  state_t        state_q, state_d;
  logic [CW-1:0] wait_q, wait_d;
  logic [15:0]   pc_q, pc_d, ir_q, ir_d;
  logic          err_q, err_d;
  logic          active, step, timeout;
  always_comb begin
    active  = state_q != HALT;
    step    = active && (state_q != FETCH || bus.mem_ready);
    // wait_q counts earlier low cycles, so this is the WAIT_LIMIT-th one
    timeout = state_q == FETCH && !bus.mem_ready && wait_q == CW'(WAIT_LIMIT - 1);
    state_d = state_q;
    case (state_q)
      HALT:    state_d = bus.run ? FETCH : HALT;
      FETCH:   state_d = bus.mem_ready ? EXEC1 : timeout ? HALT : FETCH;
      EXEC1:   state_d = bus.halt_req ? HALT : bus.sm_extra ? EXEC2 : FETCH;
      default: state_d = bus.halt_req ? HALT : FETCH;
    endcase
    wait_d = (state_q == FETCH && !bus.mem_ready && !timeout) ? wait_q + 1'b1 : '0;
    err_d  = timeout | (err_q & !(state_q == HALT && bus.run));
    ir_d   = (active && bus.ir_en && bus.mem_ready) ? bus.ram_q : ir_q;
    pc_d   = !step ? pc_q : bus.pc_sload ? bus.pc_load_value : bus.pc_cnt_en ? pc_q + 16'd1 : pc_q;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= HALT;
      wait_q  <= '0;
      pc_q    <= '0;
      ir_q    <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
      pc_q    <= pc_d;
      ir_q    <= ir_d;
      err_q   <= err_d;
    end
  end
  assign bus.state       = state_q;
  assign bus.instruction = ir_q;
  assign bus.pc          = pc_q;
  assign bus.halted      = state_q == HALT;
  assign bus.bus_err     = err_q;
endmodule

// File: tb/tb_fetch_sequencer.sv
// tb_fetch_sequencer: directed and random checks of fetch_sequencer against a phase-level model.
module tb_fetch_sequencer;
  localparam int WL = 15;
  localparam int P_HALT = 0, P_FETCH = 1, P_EXEC1 = 2, P_EXEC2 = 3;
  localparam logic [1:0] CODE [4] = '{2'b11, 2'b00, 2'b10, 2'b01};
  logic clk = 1'b0;
  logic reset;
  int checks = 0, errors = 0;
  int ph = P_HALT, mwait = 0;
  logic [15:0] mpc = '0, mir = '0;
  logic merr = 1'b0;
  fetch_sequencer_if bus ();
  fetch_sequencer #(.WAIT_LIMIT(WL)) dut (.clk(clk), .reset(reset), .bus(bus));
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask
  task automatic idle();
    bus.run = 0; bus.halt_req = 0; bus.mem_ready = 1; bus.ram_q = '0; bus.ir_en = 0;
    bus.pc_cnt_en = 0; bus.pc_sload = 0; bus.pc_load_value = '0; bus.sm_extra = 0;
  endtask
  task automatic model_step();
    bit go;
    if (reset) begin
      ph = P_HALT; mpc = '0; mir = '0; merr = 0; mwait = 0;
    end else if (ph == P_HALT) begin
      if (bus.run) begin ph = P_FETCH; merr = 0; mwait = 0; end
    end else begin
      go = ph != P_FETCH || bus.mem_ready;
      if (bus.ir_en && bus.mem_ready) mir = bus.ram_q;
      if (go) mpc = bus.pc_sload ? bus.pc_load_value : mpc + 16'(bus.pc_cnt_en);
      if (ph == P_FETCH) begin
        if (bus.mem_ready) ph = P_EXEC1;
        else begin
          mwait++;
          if (mwait >= WL) begin ph = P_HALT; merr = 1; end
        end
      end else if (bus.halt_req) ph = P_HALT;
      else if (ph == P_EXEC1 && bus.sm_extra) ph = P_EXEC2;
      else begin ph = P_FETCH; mwait = 0; end
    end
  endtask
  task automatic cycle(input string tag);
    model_step();
    @(posedge clk);
    #1;
    chk({tag, ".state"}, 16'(bus.state), 16'(CODE[ph]));
    chk({tag, ".pc"}, bus.pc, mpc);
    chk({tag, ".ir"}, bus.instruction, mir);
    chk({tag, ".halted"}, 16'(bus.halted), 16'(ph == P_HALT));
    chk({tag, ".bus_err"}, 16'(bus.bus_err), 16'(merr));
  endtask
  initial begin
    idle();
    reset = 1;
    cycle("reset");
    chk("reset_code", 16'(bus.state), 16'h3);
    reset = 0;
    bus.ram_q = 16'h4C00; bus.ir_en = 1; bus.pc_cnt_en = 1; bus.run = 1;
    cycle("start");
    bus.run = 0;
    cycle("fetch1");
    bus.ir_en = 0; bus.pc_cnt_en = 0;
    cycle("exec1a");
    bus.ir_en = 1; bus.pc_cnt_en = 1;
    cycle("fetch2");
    chk("seq_pc", bus.pc, 16'd2);
    chk("seq_ir", bus.instruction, 16'h4C00);
    chk("seq_state", 16'(bus.state), 16'h2);
    bus.ir_en = 0; bus.pc_cnt_en = 0; bus.sm_extra = 1;
    cycle("to_exec2");
    chk("exec2_code", 16'(bus.state), 16'h1);
    cycle("exec2_out");
    bus.sm_extra = 0; bus.mem_ready = 0; bus.ir_en = 1; bus.pc_cnt_en = 1; bus.ram_q = 16'h1234;
    repeat (3) cycle("wait3");
    bus.mem_ready = 1;
    cycle("wait3_done");
    chk("wait3_ir", bus.instruction, 16'h1234);
    bus.ir_en = 0; bus.pc_cnt_en = 0;
    cycle("back_fetch");
    bus.mem_ready = 0;
    repeat (WL - 1) cycle("wait_edge");
    bus.mem_ready = 1;
    cycle("edge_ready");
    chk("edge_no_err", 16'(bus.bus_err), 16'h0);
    cycle("exec1_b");
    bus.mem_ready = 0;
    repeat (WL - 1) cycle("wait_to");
    cycle("timeout");
    chk("timeout_err", 16'(bus.bus_err), 16'h1);
    chk("timeout_halted", 16'(bus.halted), 16'h1);
    bus.mem_ready = 1; bus.halt_req = 1;
    cycle("halt_idle");
    bus.halt_req = 0; bus.run = 1;
    cycle("rerun");
    bus.run = 0;
    cycle("fetch3");
    bus.pc_sload = 1; bus.pc_cnt_en = 1; bus.pc_load_value = 16'h0123; bus.halt_req = 1; bus.sm_extra = 1;
    cycle("sload_halt");
    chk("sload_pc", bus.pc, 16'h0123);
    bus.halt_req = 0; bus.sm_extra = 0; bus.run = 1; bus.pc_cnt_en = 0;
    cycle("rerun2");
    bus.run = 0; bus.pc_load_value = 16'hFFFF;
    cycle("load_ffff");
    bus.pc_sload = 0; bus.pc_cnt_en = 1;
    cycle("wrap");
    chk("wrap_pc", bus.pc, 16'h0000);
    bus.pc_cnt_en = 0; bus.mem_ready = 0;
    repeat (2) cycle("pre_rst_wait");
    reset = 1; bus.run = 1;
    cycle("rst_in_wait");
    reset = 0;
    cycle("run_after_rst");
    bus.run = 0; bus.mem_ready = 1;
    cycle("fetch4");
    bus.sm_extra = 1; bus.ir_en = 1; bus.ram_q = 16'hBEEF;
    cycle("exec1_c");
    reset = 1;
    cycle("rst_in_exec2");
    chk("rst_exec2_pc", bus.pc, 16'h0000);
    reset = 0; idle();
    for (int i = 0; i < 500; i++) begin
      reset = ($urandom_range(0, 49) == 0);
      bus.run = ($urandom_range(0, 3) == 0);
      bus.halt_req = ($urandom_range(0, 7) == 0);
      bus.mem_ready = ($urandom_range(0, 3) != 0) || (i >= 200 && i < 260);
      if (i >= 200 && i < 260) bus.mem_ready = (i % 20 == 19);
      bus.ram_q = 16'($urandom);
      bus.ir_en = 1'($urandom);
      bus.pc_cnt_en = 1'($urandom);
      bus.pc_sload = ($urandom_range(0, 5) == 0);
      bus.pc_load_value = ($urandom_range(0, 3) == 0) ? 16'hFFFF : 16'($urandom);
      bus.sm_extra = 1'($urandom);
      cycle("rand");
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
